// File: rtl/sequenciador_preparo_if.sv
// Handshake and valve bus of the drink-preparation sequencer.
// The master drives the request side; the sequencer (slave) drives the valve side.
interface sequenciador_preparo_if;
   logic       INICIAR;
   logic [1:0] BEBIDA;
   logic       CANCELAR;
   logic [3:0] VALVULA;
   logic [1:0] ETAPA;
   logic       OCUPADO;
   logic       PRONTO;

   modport master (
      output INICIAR, BEBIDA, CANCELAR,
      input  VALVULA, ETAPA, OCUPADO, PRONTO
   );

   modport slave (
      input  INICIAR, BEBIDA, CANCELAR,
      output VALVULA, ETAPA, OCUPADO, PRONTO
   );
endinterface

// File: rtl/sequenciador_preparo.sv
// Coffee-machine sequencer: water, coffee, optional milk, optional sugar, then a
// one-cycle completion pulse. Outputs are flops loaded from the decoded next state.
module sequenciador_preparo #(
   parameter int CW       = 8,
   parameter int T_AGUA   = 8,
   parameter int T_CAFE   = 4,
   parameter int T_LEITE  = 4,
   parameter int T_ACUCAR = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   sequenciador_preparo_if.slave bus
);

   typedef enum logic [2:0] {
      OCIOSO = 3'd0,
      AGUA   = 3'd1,
      CAFE   = 3'd2,
      LEITE  = 3'd3,
      ACUCAR = 3'd4,
      FIM    = 3'd5
   } estado_t;

   localparam logic [CW-1:0] CARGA_AGUA   = CW'(T_AGUA - 1);
   localparam logic [CW-1:0] CARGA_CAFE   = CW'(T_CAFE - 1);
   localparam logic [CW-1:0] CARGA_LEITE  = CW'(T_LEITE - 1);
   localparam logic [CW-1:0] CARGA_ACUCAR = CW'(T_ACUCAR - 1);
   localparam logic [CW-1:0] ZERO         = {CW{1'b0}};
   localparam logic [CW-1:0] UM           = {{(CW-1){1'b0}}, 1'b1};

   estado_t       estado_q, estado_d;
   logic [CW-1:0] cont_q, cont_d;
   logic [1:0]    bebida_q, bebida_d;
   logic [3:0]    valvula_q, valvula_d;
   logic [1:0]    etapa_q, etapa_d;
   logic          ocupado_q, ocupado_d;
   logic          pronto_q, pronto_d;
   logic          fim_etapa_s;

   function automatic logic [3:0] valvula_de(input estado_t e);
      case (e)
         AGUA:    valvula_de = 4'b0001;
         CAFE:    valvula_de = 4'b0010;
         LEITE:   valvula_de = 4'b0100;
         ACUCAR:  valvula_de = 4'b1000;
         default: valvula_de = 4'b0000;
      endcase
   endfunction

   function automatic logic [1:0] etapa_de(input estado_t e);
      case (e)
         CAFE:    etapa_de = 2'd1;
         LEITE:   etapa_de = 2'd2;
         ACUCAR:  etapa_de = 2'd3;
         default: etapa_de = 2'd0;
      endcase
   endfunction

   // State, counter, latched selection and output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         estado_q  <= OCIOSO;
         cont_q    <= ZERO;
         bebida_q  <= 2'b00;
         valvula_q <= 4'b0000;
         etapa_q   <= 2'd0;
         ocupado_q <= 1'b0;
         pronto_q  <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         cont_q    <= cont_d;
         bebida_q  <= bebida_d;
         valvula_q <= valvula_d;
         etapa_q   <= etapa_d;
         ocupado_q <= ocupado_d;
         pronto_q  <= pronto_d;
      end
   end

   assign fim_etapa_s = (cont_q == ZERO);

   // Next state: cancel beats stage advance; disabled stages are skipped in zero cycles.
   always_comb begin
      estado_d = estado_q;
      cont_d   = cont_q;
      bebida_d = bebida_q;
      case (estado_q)
         OCIOSO: begin
            if (bus.INICIAR && !bus.CANCELAR) begin
               estado_d = AGUA;
               cont_d   = CARGA_AGUA;
               bebida_d = bus.BEBIDA;
            end else begin
               estado_d = OCIOSO;
            end
         end
         AGUA, CAFE, LEITE, ACUCAR: begin
            if (bus.CANCELAR) begin
               estado_d = OCIOSO;
               cont_d   = ZERO;
            end else if (!fim_etapa_s) begin
               cont_d = cont_q - UM;
            end else if (estado_q == AGUA) begin
               estado_d = CAFE;
               cont_d   = CARGA_CAFE;
            end else if (estado_q == CAFE && bebida_q[0]) begin
               estado_d = LEITE;
               cont_d   = CARGA_LEITE;
            end else if (estado_q != ACUCAR && bebida_q[1]) begin
               estado_d = ACUCAR;
               cont_d   = CARGA_ACUCAR;
            end else begin
               estado_d = FIM;
               cont_d   = ZERO;
            end
         end
         FIM: begin
            estado_d = OCIOSO;
            cont_d   = ZERO;
         end
         default: begin
            estado_d = OCIOSO;
            cont_d   = ZERO;
         end
      endcase
   end

   // Moore decode of the next state, so the registered outputs match estado_q.
   always_comb begin
      valvula_d = valvula_de(estado_d);
      etapa_d   = etapa_de(estado_d);
      ocupado_d = (estado_d != OCIOSO);
      pronto_d  = (estado_d == FIM);
   end

   assign bus.VALVULA = valvula_q;
   assign bus.ETAPA   = etapa_q;
   assign bus.OCUPADO = ocupado_q;
   assign bus.PRONTO  = pronto_q;

endmodule

// File: tb/tb_sequenciador_preparo.sv
// Directed bench for sequenciador_preparo with default parameters; expectations
// are packed as {PRONTO, OCUPADO, ETAPA, VALVULA}.
module tb_sequenciador_preparo;

   logic CLK = 1'b0;
   logic RST;
   int   nvec = 0;
   int   nerr = 0;

   sequenciador_preparo_if bus ();

   sequenciador_preparo dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] esp(input logic pronto, input logic ocup,
                                      input logic [1:0] etapa, input logic [3:0] valv);
      esp = {pronto, ocup, etapa, valv};
   endfunction

   task automatic chk(input string tag, input logic [7:0] exp_v);
      logic [7:0] obs;
      obs = {bus.PRONTO, bus.OCUPADO, bus.ETAPA, bus.VALVULA};
      nvec++;
      assert (obs === exp_v)
      else begin
         nerr++;
         $error("FAIL %s: observed %b expected %b (PRONTO,OCUPADO,ETAPA,VALVULA)", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic seg(input string tag, input logic [3:0] valv, input logic [1:0] etapa, input int n);
      for (int i = 0; i < n; i++) begin
         chk(tag, esp(1'b0, 1'b1, etapa, valv));
         tick();
      end
   endtask

   task automatic iniciar(input logic [1:0] b);
      bus.INICIAR = 1'b1;
      bus.BEBIDA  = b;
      tick();
      bus.INICIAR = 1'b0;
   endtask

   task automatic fim_e_ocioso(input string tag);
      chk({tag, "_pronto"}, esp(1'b1, 1'b1, 2'd0, 4'b0000));
      tick();
      chk({tag, "_ocioso"}, esp(1'b0, 1'b0, 2'd0, 4'b0000));
      tick();
      chk({tag, "_ocioso2"}, esp(1'b0, 1'b0, 2'd0, 4'b0000));
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST          = 1'b0;
      bus.INICIAR  = 1'b0;
      bus.BEBIDA   = 2'b00;
      bus.CANCELAR = 1'b0;
      #3;
      chk("reset", esp(1'b0, 1'b0, 2'd0, 4'b0000));
      tick();
      RST = 1'b1;
      tick();
      chk("idle_after_reset", esp(1'b0, 1'b0, 2'd0, 4'b0000));

      // Asynchronous reset during water cycle 3.
      iniciar(2'b11);
      seg("rst_agua", 4'b0001, 2'd0, 2);
      chk("rst_agua_c3", esp(1'b0, 1'b1, 2'd0, 4'b0001));
      #2;
      RST = 1'b0;
      #1;
      chk("rst_async", esp(1'b0, 1'b0, 2'd0, 4'b0000));
      tick();
      RST = 1'b1;
      tick();
      chk("rst_stay_idle1", esp(1'b0, 1'b0, 2'd0, 4'b0000));
      tick();
      chk("rst_stay_idle2", esp(1'b0, 1'b0, 2'd0, 4'b0000));

      // BEBIDA=00: water x8, coffee x4, PRONTO at cycle 13.
      iniciar(2'b00);
      seg("b00_agua", 4'b0001, 2'd0, 8);
      seg("b00_cafe", 4'b0010, 2'd1, 4);
      fim_e_ocioso("b00");

      // BEBIDA=11: all four stages, PRONTO at cycle 19.
      iniciar(2'b11);
      seg("b11_agua", 4'b0001, 2'd0, 8);
      seg("b11_cafe", 4'b0010, 2'd1, 4);
      seg("b11_leite", 4'b0100, 2'd2, 4);
      seg("b11_acucar", 4'b1000, 2'd3, 2);
      fim_e_ocioso("b11");

      // BEBIDA=10 latched; change to 01 in cycle 2 must not matter.
      iniciar(2'b10);
      seg("b10_agua", 4'b0001, 2'd0, 1);
      bus.BEBIDA = 2'b01;
      seg("b10_agua", 4'b0001, 2'd0, 7);
      seg("b10_cafe", 4'b0010, 2'd1, 4);
      seg("b10_acucar", 4'b1000, 2'd3, 2);
      fim_e_ocioso("b10");

      // Cancel at edge ending coffee cycle 2; INICIAR pulses in cycles 3-9 ignored.
      iniciar(2'b11);
      seg("can_agua", 4'b0001, 2'd0, 2);
      bus.INICIAR = 1'b1;
      seg("can_agua", 4'b0001, 2'd0, 6);
      seg("can_cafe", 4'b0010, 2'd1, 1);
      bus.INICIAR  = 1'b0;
      bus.CANCELAR = 1'b1;
      chk("can_cafe_c10", esp(1'b0, 1'b1, 2'd1, 4'b0010));
      tick();
      bus.CANCELAR = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("can_idle_no_pronto", esp(1'b0, 1'b0, 2'd0, 4'b0000));
         tick();
      end

      // INICIAR with CANCELAR in idle: start dropped.
      bus.INICIAR  = 1'b1;
      bus.CANCELAR = 1'b1;
      tick();
      chk("ini_can_idle1", esp(1'b0, 1'b0, 2'd0, 4'b0000));
      tick();
      chk("ini_can_idle2", esp(1'b0, 1'b0, 2'd0, 4'b0000));
      bus.INICIAR  = 1'b0;
      bus.CANCELAR = 1'b0;
      tick();

      // INICIAR held through FIM: ignored there, accepted from the next idle cycle.
      bus.INICIAR = 1'b1;
      bus.BEBIDA  = 2'b00;
      tick();
      seg("hold_agua", 4'b0001, 2'd0, 8);
      seg("hold_cafe", 4'b0010, 2'd1, 4);
      chk("hold_pronto", esp(1'b1, 1'b1, 2'd0, 4'b0000));
      tick();
      chk("hold_fim_ignored", esp(1'b0, 1'b0, 2'd0, 4'b0000));
      tick();
      bus.INICIAR = 1'b0;
      seg("hold_rerun_agua", 4'b0001, 2'd0, 8);
      seg("hold_rerun_cafe", 4'b0010, 2'd1, 4);
      fim_e_ocioso("hold_rerun");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
